xswitch_out_arbiter: RTL and testbench
======================================

# xswitch_out_arbiter

Per-output-port scheduler for the xswitch. It accepts 8-bit words from NUM_IN downstream-style input ports through a valid/ready handshake. Each input has a one-word holding register, and words are captured only when their address matches this port. Holding registers are granted round-robin onto a single upstream-style output port, which is held until the consumer strobes data_rd. One instance sits in front of each switch output.

## Interface
- NUM_IN, 4: number of input ports (2..8).
- PORT_ID, 8'h00: address this output serves; only words with addr equal to PORT_ID are accepted.
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  NUM_IN  per-input word valid.
- addr_in  in  8*NUM_IN  per-input address; input i uses bits [8i+7:8i].
- data_in  in  8*NUM_IN  per-input data; input i uses bits [8i+7:8i].
- rcv_rdy  out  NUM_IN  per-input ready; rcv_rdy[i] = ~hold_full[i] & ~reset.
- data_out  out  8  granted word data, registered.
- addr_out  out  8  granted word address, registered; always PORT_ID while valid_out=1.
- valid_out  out  1  output word valid, registered.
- data_rd  in  1  consumer read strobe; ignored while valid_out=0.
- fwd_count  out  16  words delivered (data_rd sampled with valid_out=1); wraps 16'hFFFF -> 0.

## Operation
- Capture rule for input i, at a clock edge:
  - if valid_in[i]=1, rcv_rdy[i]=1 and addr_in[i]=PORT_ID, then the data and address load into hold[i] and hold_full[i] is set.
  - Non-matching words are ignored and do not change rcv_rdy.
- Output FSM, two states:
  - IDLE: valid_out=0. If any hold_full is set, grant the winner: load its data into the output register, clear its hold_full, and go to BUSY.
  - BUSY: valid_out=1, with data_out and addr_out held stable.
    - On data_rd=1 with a pending winner: load the winner in the same edge and stay in BUSY (back-to-back).
    - On data_rd=1 with nothing pending: go to IDLE and clear valid_out. data_out and addr_out keep their last value.
    - On data_rd=0: stay in BUSY.
- Round-robin arbitration:
  - ptr (log2 NUM_IN bits) marks the highest-priority input.
  - The winner is the first set hold_full scanning ptr, ptr+1, ... mod NUM_IN.
  - After granting input k, ptr = (k+1) mod NUM_IN. ptr changes only on a grant.
- fwd_count increments on every edge with valid_out=1 and data_rd=1.

## Timing
- Reset values (after one edge with reset=1): valid_out=0, data_out=8'h00, addr_out=8'h00, fwd_count=0, ptr=0, all hold_full=0, FSM=IDLE. rcv_rdy=0 while reset=1.
- Latency:
  - Word accepted at edge N -> hold_full at N+1 -> valid_out=1 after edge N+1, if the output is idle.
  - Input-to-output latency is 2 cycles minimum.
- Throughput: 1 word/cycle with data_rd held high and inputs pending. The freed hold[k] shows rcv_rdy[k]=1 in the cycle after the grant.
- A grant and a new capture on the same input never occur at the same edge, because rcv_rdy was 0 that cycle.
- data_rd sampled at edge M:
  - Next word visible after M when one is pending.
  - Otherwise valid_out=0 after M.
- Reset mid-operation: held and in-flight words are discarded, and the output drops valid_out within one edge. No partial word is delivered.

## Test plan
- Reset: hold reset 2 cycles mid-traffic -> valid_out=0, data_out=8'h00, fwd_count=0, rcv_rdy=4'b0000 during reset, 4'b1111 on the first cycle after.
- Single word, latency and hold:
  - Input 2 sends data 8'hA5, addr 8'h00, with data_rd=0 -> valid_out=1 two cycles later, data_out=8'hA5, addr_out=8'h00, stable for 5 cycles.
  - Then data_rd=1 for one cycle -> valid_out=0, fwd_count=1.
- Address filter: input 1 sends addr 8'h03 -> no capture, rcv_rdy[1] stays 1, valid_out stays 0.
- Contention:
  - Inputs 0..3 send 8'h10..8'h13 in the same cycle, data_rd held 1 -> output 8'h10, 8'h11, 8'h12, 8'h13 on consecutive cycles; ptr=0 afterwards.
  - Then, after granting input 1 (ptr=2), inputs 1 and 3 contend -> 3 is granted before 1.
- Backpressure:
  - data_rd=0, input 0 sends 8'h01 then 8'h02 -> 8'h01 is granted; 8'h02 is captured the cycle after rcv_rdy[0] returns high.
  - With 8'h02 held, rcv_rdy[0]=0 until data_rd=1. Then 8'h02 follows back-to-back and fwd_count=2.
- fwd_count wrap: preload via 65536 deliveries (or force) -> 16'hFFFF rolls to 16'h0000 on the next delivery.

Source files
------------

// File: rtl/xswitch_out_arbiter.sv
// xswitch_out_arbiter: per-output-port scheduler for the xswitch.
// Each input owns a one-word holding register that captures only words
// addressed to PORT_ID. Full holding registers are granted round-robin
// onto a single registered output that is held until the consumer reads it.
module xswitch_out_arbiter #(
    parameter int          NUM_IN  = 4,
    parameter logic [7:0]  PORT_ID = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_IN-1:0]     valid_in,
    input  logic [8*NUM_IN-1:0]   addr_in,
    input  logic [8*NUM_IN-1:0]   data_in,
    output logic [NUM_IN-1:0]     rcv_rdy,
    output logic [7:0]            data_out,
    output logic [7:0]            addr_out,
    output logic                  valid_out,
    input  logic                  data_rd,
    output logic [15:0]           fwd_count
);

    localparam int PTR_W = $clog2(NUM_IN);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             state_q;
    logic               hold_full_q [NUM_IN];
    logic [7:0]         hold_data_q [NUM_IN];
    logic [7:0]         hold_addr_q [NUM_IN];
    logic [NUM_IN-1:0]  hold_full;
    logic [NUM_IN-1:0]  capture;
    logic [NUM_IN-1:0]  grant_vec;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic [PTR_W-1:0]   win_idx;
    logic               win_found;
    logic               grant;
    logic [7:0]         data_out_q;
    logic [7:0]         addr_out_q;
    logic               valid_out_q;
    logic [15:0]        fwd_count_q;

    // Ready is withheld during reset so nothing is handshaken while state is being cleared.
    assign rcv_rdy = ~hold_full & {NUM_IN{~reset}};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_hold
            assign hold_full[gi] = hold_full_q[gi];
            assign capture[gi]   = valid_in[gi] & rcv_rdy[gi] &
                                   (addr_in[8*gi +: 8] == PORT_ID);
            assign grant_vec[gi] = grant & (win_idx == PTR_W'(gi));

            // Holding register: capture a matching word, release it when granted.
            // Capture and grant cannot coincide because ready is low while full.
            always_ff @(posedge clk) begin
                if (reset) begin
                    hold_full_q[gi] <= 1'b0;
                    hold_data_q[gi] <= 8'h00;
                    hold_addr_q[gi] <= 8'h00;
                end else if (capture[gi]) begin
                    hold_full_q[gi] <= 1'b1;
                    hold_data_q[gi] <= data_in[8*gi +: 8];
                    hold_addr_q[gi] <= addr_in[8*gi +: 8];
                end else if (grant_vec[gi]) begin
                    hold_full_q[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Round-robin winner: first full holding register scanning from ptr upward.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_IN) begin
                j = j - NUM_IN;
            end
            if (!win_found && hold_full[j[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(j);
            end
        end
    end

    // A grant happens when a word is pending and the output register is free
    // now (idle) or is being freed at this edge (busy with a read).
    assign grant = win_found & ((state_q == S_IDLE) | data_rd);
    assign ptr_d = (win_idx == PTR_W'(NUM_IN - 1)) ? '0 : win_idx + 1'b1;

    // Output FSM with registered outputs, pointer update and delivery counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            valid_out_q <= 1'b0;
            data_out_q  <= 8'h00;
            addr_out_q  <= 8'h00;
            ptr_q       <= '0;
            fwd_count_q <= 16'h0000;
        end else begin
            if (valid_out_q && data_rd) begin
                fwd_count_q <= fwd_count_q + 16'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        data_out_q  <= hold_data_q[win_idx];
                        addr_out_q  <= hold_addr_q[win_idx];
                        valid_out_q <= 1'b1;
                        ptr_q       <= ptr_d;
                        state_q     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (data_rd) begin
                        if (grant) begin
                            data_out_q <= hold_data_q[win_idx];
                            addr_out_q <= hold_addr_q[win_idx];
                            ptr_q      <= ptr_d;
                        end else begin
                            // Last data/address stay visible; only valid drops.
                            valid_out_q <= 1'b0;
                            state_q     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    valid_out_q <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_out_q;
    assign addr_out  = addr_out_q;
    assign valid_out = valid_out_q;
    assign fwd_count = fwd_count_q;

endmodule

// File: tb/tb_xswitch_out_arbiter.sv
// Scoreboard bench for xswitch_out_arbiter: stimulus pushes expected words,
// a negedge monitor pops and compares on every delivery (valid_out & data_rd).
module tb_xswitch_out_arbiter;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      valid_in;
    logic [8*N-1:0]    addr_in;
    logic [8*N-1:0]    data_in;
    logic [N-1:0]      rcv_rdy;
    logic [7:0]        data_out;
    logic [7:0]        addr_out;
    logic              valid_out;
    logic              data_rd;
    logic [15:0]       fwd_count;

    int                total  = 0;
    int                bad    = 0;
    int                n_deliv = 0;
    bit                quiet  = 1'b0;
    logic [7:0]        exp_q [$];
    logic [7:0]        mon_e;

    xswitch_out_arbiter #(.NUM_IN(N), .PORT_ID(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .rcv_rdy   (rcv_rdy),
        .data_out  (data_out),
        .addr_out  (addr_out),
        .valid_out (valid_out),
        .data_rd   (data_rd),
        .fwd_count (fwd_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i, input logic [7:0] a, input logic [7:0] d);
        valid_in[i]       = 1'b1;
        addr_in[8*i +: 8] = a;
        data_in[8*i +: 8] = d;
    endtask

    // Monitor: every delivery pops the scoreboard and compares.
    always @(negedge clk) begin
        if (!reset && valid_out && data_rd) begin
            n_deliv++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL deliver: got data %02h, required none (scoreboard empty)", data_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (!quiet) begin
                    $display("deliver data=%02h addr=%02h expected=%02h", data_out, addr_out, mon_e);
                end
                chk("deliver_data", 32'(data_out), 32'(mon_e));
                chk("deliver_addr", 32'(addr_out), 32'h00);
            end
        end
    end

    initial begin
        int accepted;
        bit seen_ffff;
        bit seen_zero;
        bit done;

        reset    = 1'b1;
        valid_in = '0;
        addr_in  = '0;
        data_in  = '0;
        data_rd  = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(valid_out), 32'h0);
        chk("rst_data",  32'(data_out),  32'h00);
        chk("rst_addr",  32'(addr_out),  32'h00);
        chk("rst_fwd",   32'(fwd_count), 32'h0);
        chk("rst_rdy",   32'(rcv_rdy),   32'h0);
        reset = 1'b0;
        #1;
        chk("rst_rdy_after", 32'(rcv_rdy), 32'hF);

        // Reset in the middle of traffic: held and in-flight words vanish.
        tick();
        for (int i = 0; i < N; i++) set_in(i, 8'h00, 8'(8'h30 + i));
        tick();
        valid_in = '0;
        tick();
        chk("mt_valid_busy", 32'(valid_out), 32'h1);
        reset = 1'b1;
        #1;
        chk("mt_rdy_in_reset", 32'(rcv_rdy), 32'h0);
        tick();
        chk("mt_rdy_in_reset2", 32'(rcv_rdy),  32'h0);
        tick();
        chk("mt_valid", 32'(valid_out), 32'h0);
        chk("mt_data",  32'(data_out),  32'h00);
        chk("mt_fwd",   32'(fwd_count), 32'h0);
        reset = 1'b0;
        #1;
        chk("mt_rdy_after", 32'(rcv_rdy), 32'hF);
        tick();
        chk("mt_no_output", 32'(valid_out), 32'h0);

        // Single word: latency 2, held while data_rd=0.
        set_in(2, 8'h00, 8'hA5);
        exp_q.push_back(8'hA5);
        tick();
        valid_in = '0;
        chk("sw_lat1_valid", 32'(valid_out), 32'h0);
        tick();
        chk("sw_valid", 32'(valid_out), 32'h1);
        chk("sw_data",  32'(data_out),  32'hA5);
        chk("sw_addr",  32'(addr_out),  32'h00);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("sw_hold_valid", 32'(valid_out), 32'h1);
            chk("sw_hold_data",  32'(data_out),  32'hA5);
        end
        data_rd = 1'b1;
        tick();
        data_rd = 1'b0;
        chk("sw_done_valid", 32'(valid_out), 32'h0);
        chk("sw_keep_data",  32'(data_out),  32'hA5);
        chk("sw_fwd",        32'(fwd_count), 32'h1);

        // Address filter: non-matching word is ignored.
        set_in(1, 8'h03, 8'h77);
        tick();
        valid_in = '0;
        chk("af_rdy1",  32'(rcv_rdy[1]), 32'h1);
        chk("af_valid", 32'(valid_out),  32'h0);
        tick();
        chk("af_valid2", 32'(valid_out), 32'h0);

        // Fresh pointer for the contention pattern.
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        n_deliv = 0;

        // Contention: all four inputs at once, data_rd held high.
        for (int i = 0; i < N; i++) begin
            set_in(i, 8'h00, 8'(8'h10 + i));
            exp_q.push_back(8'(8'h10 + i));
        end
        data_rd = 1'b1;
        tick();
        valid_in = '0;
        chk("ct_lat_valid", 32'(valid_out), 32'h0);
        for (int k = 0; k < N; k++) begin
            tick();
            chk("ct_valid", 32'(valid_out), 32'h1);
            chk("ct_data",  32'(data_out),  32'(8'h10 + k));
        end
        tick();
        chk("ct_idle", 32'(valid_out), 32'h0);

        // Grant input 1 (pointer moves to 2), then 1 and 3 contend: 3 wins.
        set_in(1, 8'h00, 8'h21);
        exp_q.push_back(8'h21);
        tick();
        valid_in = '0;
        tick();
        chk("rr_first", 32'(data_out), 32'h21);
        set_in(1, 8'h00, 8'h31);
        set_in(3, 8'h00, 8'h33);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h31);
        tick();
        valid_in = '0;
        chk("rr_gap", 32'(valid_out), 32'h0);
        tick();
        chk("rr_win3", 32'(data_out), 32'h33);
        tick();
        chk("rr_then1", 32'(data_out), 32'h31);
        tick();
        chk("rr_idle", 32'(valid_out), 32'h0);
        data_rd = 1'b0;

        // Backpressure on input 0.
        set_in(0, 8'h00, 8'h01);
        exp_q.push_back(8'h01);
        tick();
        set_in(0, 8'h00, 8'h02);
        exp_q.push_back(8'h02);
        chk("bp_rdy_full", 32'(rcv_rdy[0]), 32'h0);
        tick();
        chk("bp_valid",     32'(valid_out),  32'h1);
        chk("bp_data1",     32'(data_out),   32'h01);
        chk("bp_rdy_freed", 32'(rcv_rdy[0]), 32'h1);
        tick();
        valid_in = '0;
        chk("bp_rdy_held", 32'(rcv_rdy[0]), 32'h0);
        tick();
        tick();
        chk("bp_rdy_held2", 32'(rcv_rdy[0]), 32'h0);
        chk("bp_data_held", 32'(data_out),   32'h01);
        data_rd = 1'b1;
        tick();
        chk("bp_b2b_valid", 32'(valid_out), 32'h1);
        chk("bp_b2b_data",  32'(data_out),  32'h02);
        tick();
        data_rd = 1'b0;
        chk("bp_idle", 32'(valid_out), 32'h0);
        chk("bp_fwd",  32'(fwd_count), 32'd9);

        // Counter wrap: 65536 deliveries at full throughput from a fresh reset.
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        n_deliv   = 0;
        quiet     = 1'b1;
        accepted  = 0;
        seen_ffff = 1'b0;
        seen_zero = 1'b0;
        done      = 1'b0;
        data_rd   = 1'b1;
        for (int c = 0; c < 70000 && !done; c++) begin
            valid_in = '0;
            for (int i = 0; i < N; i++) begin
                if (accepted < 65536 && rcv_rdy[i]) begin
                    set_in(i, 8'h00, 8'h5A);
                    exp_q.push_back(8'h5A);
                    accepted++;
                end
            end
            tick();
            if (n_deliv == 65535 && !seen_ffff) begin
                seen_ffff = 1'b1;
                chk("wrap_ffff", 32'(fwd_count), 32'hFFFF);
            end
            if (n_deliv == 65536 && !seen_zero) begin
                seen_zero = 1'b1;
                chk("wrap_zero", 32'(fwd_count), 32'h0);
            end
            if (seen_zero && !valid_out && exp_q.size() == 0) done = 1'b1;
        end
        valid_in = '0;
        data_rd  = 1'b0;
        quiet    = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL wrap_timeout: got %0d deliveries, required 65536", n_deliv);
        end
        chk("wrap_count", 32'(n_deliv), 32'd65536);
        chk("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
